generador_frecuencia: RTL and testbench



---
 rtl/generador_frecuencia.sv | 130 +++++++++++++
 tb/tb_generador_frecuencia.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/generador_frecuencia.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | generador_frecuencia: frequency word -> 50 % duty square wave            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module generador_frecuencia #(
    parameter int CLK_HZ = 100_000_000,
    parameter int F_W    = 11,
    parameter int DIV_W  = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ENg,
    input  logic [F_W-1:0]   f,
    output logic             senal,
    output logic             listo,
    output logic [DIV_W-1:0] medio_periodo
);

    localparam int               c_IDX_W     = $clog2(DIV_W);
    localparam logic [DIV_W-1:0] c_DIVIDENDO = DIV_W'(CLK_HZ / 2);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_DIVIDE  = 2'd1;
    localparam logic [1:0] c_PENDING = 2'd2;

    logic [1:0]         r_state;
    logic [F_W-1:0]     r_f_ult;
    logic [F_W-1:0]     r_divisor;
    logic [DIV_W:0]     r_rem;
    logic [DIV_W-1:0]   r_quot;
    logic [DIV_W-1:0]   r_medio;
    logic [DIV_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic               r_senal;
    logic               r_listo;
    logic               r_commit_d;

    logic [DIV_W:0]     w_div_ext;
    logic [DIV_W:0]     w_rem_shift;
    logic [DIV_W:0]     w_rem_next;
    logic               w_q_bit;
    logic [DIV_W-1:0]   w_q_next;
    logic               w_fin_fase;
    logic               w_cambio;

    // One restoring-division step: bring down the next dividend bit, MSB first.
    always_comb begin
        w_div_ext   = {{(DIV_W + 1 - F_W){1'b0}}, r_divisor};
        w_rem_shift = (r_rem << 1) | {{DIV_W{1'b0}}, c_DIVIDENDO[r_bit_idx]};
        w_q_bit     = (w_rem_shift >= w_div_ext);
        w_rem_next  = w_q_bit ? (w_rem_shift - w_div_ext) : w_rem_shift;
        w_q_next    = {r_quot[DIV_W-2:0], w_q_bit};
        w_fin_fase  = (r_medio != '0) && (r_cnt == r_medio - DIV_W'(1));
        w_cambio    = (f != r_f_ult);
    end

    always_ff @(posedge clk) begin
        if (!rst || !ENg) begin
            r_state    <= c_IDLE;
            r_f_ult    <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_bit_idx  <= '0;
            r_medio    <= '0;
            r_cnt      <= '0;
            r_senal    <= 1'b0;
            r_listo    <= 1'b0;
            r_commit_d <= 1'b0;
        end else begin
            r_commit_d <= 1'b0;
            if (r_commit_d) begin
                r_listo <= 1'b1;
            end

            if (r_medio == '0) begin
                r_cnt   <= '0;
                r_senal <= 1'b0;
            end else if (w_fin_fase) begin
                r_cnt   <= '0;
                r_senal <= ~r_senal;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end

            // A new request in any state discards whatever was in flight.
            if (w_cambio) begin
                r_f_ult   <= f;
                r_divisor <= f;
                r_listo   <= 1'b0;
                r_rem     <= '0;
                r_quot    <= '0;
                r_bit_idx <= c_IDX_W'(DIV_W - 1);
                r_state   <= (f == '0) ? c_PENDING : c_DIVIDE;
            end else begin
                case (r_state)
                    c_DIVIDE: begin
                        r_rem     <= w_rem_next;
                        r_bit_idx <= r_bit_idx - c_IDX_W'(1);
                        if (r_bit_idx == '0) begin
                            r_quot  <= (w_q_next == '0) ? DIV_W'(1) : w_q_next;
                            r_state <= c_PENDING;
                        end else begin
                            r_quot <= w_q_next;
                        end
                    end
                    c_PENDING: begin
                        if ((r_medio == '0) || w_fin_fase) begin
                            r_medio    <= r_quot;
                            r_cnt      <= '0;
                            r_state    <= c_IDLE;
                            r_commit_d <= 1'b1;
                            if (r_quot == '0) begin
                                r_senal <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign senal         = r_senal;
    assign listo         = r_listo;
    assign medio_periodo = r_medio;

endmodule
`default_nettype wire

// File: tb/tb_generador_frecuencia.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_generador_frecuencia: directed scoreboard bench for the tone generator |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_generador_frecuencia;

    localparam int CLK_HZ = 2_000_000;
    localparam int F_W    = 11;
    localparam int DIV_W  = 26;
    localparam int LAT    = DIV_W + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ENg = 1'b0;
    logic [F_W-1:0]   f   = '0;
    logic             senal;
    logic             listo;
    logic [DIV_W-1:0] medio_periodo;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    generador_frecuencia #(
        .CLK_HZ (CLK_HZ),
        .F_W    (F_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ENg           (ENg),
        .f             (f),
        .senal         (senal),
        .listo         (listo),
        .medio_periodo (medio_periodo)
    );

    function automatic int model_medio(input int fv);
        int q;
        if (fv == 0) return 0;
        q = (CLK_HZ / 2) / fv;
        if (q == 0) q = 1;
        return q;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_f(input int fv);
        f = F_W'(fv);
        exp_q.push_back(model_medio(fv));
    endtask

    task automatic score(input string tag);
        int e;
        check({tag, "_queued"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 64'(medio_periodo), 64'(e));
        end
    endtask

    // Latency counted from the capture edge (first edge after the drive).
    task automatic wait_listo(input int bound, output int lat);
        int k;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (listo !== 1'b1 && k < bound);
        lat = k - 1;
    endtask

    task automatic wait_toggle(input int bound, output int n);
        logic s0;
        s0 = senal;
        n  = 0;
        do begin
            tick(1);
            n++;
        end while (senal === s0 && n < bound);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, a, b, hits;

        rst = 1'b0; ENg = 1'b0; f = '0;
        tick(3);
        check("rst_senal", 64'(senal), 64'd0);
        check("rst_listo", 64'(listo), 64'd0);
        check("rst_medio", 64'(medio_periodo), 64'd0);
        rst = 1'b1;
        tick(2);

        // 1: silent start at 1000 Hz
        ENg = 1'b1;
        apply_f(1000);
        wait_listo(200, lat);
        check("t1_latency", 64'(lat), 64'(LAT));
        score("t1_medio");
        wait_toggle(5000, n);
        check("t1_first_low", 64'(n + 1), 64'd1000);
        wait_toggle(5000, n);
        check("t1_high", 64'(n), 64'd1000);
        wait_toggle(5000, n);
        check("t1_low", 64'(n), 64'd1000);

        // 2: switch to 2000 Hz in the middle of a high phase
        tick(300);
        apply_f(2000);
        wait_toggle(5000, n);
        check("t2_phase_end", 64'(300 + n), 64'd1000);
        tick(1);
        check("t2_listo", 64'(listo), 64'd1);
        score("t2_medio");
        wait_toggle(5000, n);
        check("t2_low", 64'(n + 1), 64'd500);
        wait_toggle(5000, n);
        check("t2_high", 64'(n), 64'd500);

        // 3: maximum frequency word
        apply_f(2047);
        wait_listo(3000, lat);
        check("t3_listo", 64'(listo), 64'd1);
        score("t3_medio");
        wait_toggle(3000, n);
        wait_toggle(3000, a);
        wait_toggle(3000, b);
        check("t3_period", 64'(a + b), 64'(2 * model_medio(2047)));

        // 4: disable, then abort a division in flight
        ENg = 1'b0;
        tick(1);
        check("t4_off_senal", 64'(senal), 64'd0);
        check("t4_off_listo", 64'(listo), 64'd0);
        check("t4_off_medio", 64'(medio_periodo), 64'd0);
        ENg = 1'b1;
        f   = F_W'(1000);
        tick(10);
        apply_f(500);
        wait_listo(200, lat);
        check("t4_latency", 64'(lat), 64'(LAT));
        score("t4_medio");

        // 5: silence from the middle of a high phase
        tick(2300);
        check("t5_high_before", 64'(senal), 64'd1);
        apply_f(0);
        wait_listo(6000, lat);
        check("t5_listo", 64'(listo), 64'd1);
        score("t5_medio");
        check("t5_senal", 64'(senal), 64'd0);
        hits = 0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (senal !== 1'b0) hits++;
        end
        check("t5_silent", 64'(hits), 64'd0);
        ENg = 1'b0;
        tick(1);
        check("t5_listo_off", 64'(listo), 64'd0);

        // 6: reset in the middle of a high phase
        ENg = 1'b1;
        apply_f(1000);
        wait_listo(200, lat);
        check("t6_latency", 64'(lat), 64'(LAT));
        score("t6_medio");
        tick(1200);
        check("t6_high_before", 64'(senal), 64'd1);
        rst = 1'b0;
        tick(1);
        check("t6_rst_senal", 64'(senal), 64'd0);
        check("t6_rst_listo", 64'(listo), 64'd0);
        check("t6_rst_medio", 64'(medio_periodo), 64'd0);
        rst = 1'b1;
        apply_f(1000);
        wait_listo(200, lat);
        check("t6_relatency", 64'(lat), 64'(LAT));
        score("t6_remedio");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
